uart_rx_cmd_decoder: RTL and testbench
======================================

Name: uart_rx_cmd_decoder

Overview:
Command-frame controller directly downstream of the UART receiver. It consumes received bytes (parallel data plus one-cycle valid) and decodes frames into register-file write/read strobes and ALU operations. It returns read data and ALU results as bytes to the TX-side FIFO write port. Runs in the reference (system) clock domain; RX data arrives already synchronised.

Parameters:
DATA_WIDTH, 8, width of RX/TX bytes, register data and ALU operands
ADDR_WIDTH, 4, register-file address width; address byte bits [ADDR_WIDTH-1:0] are used, the rest are ignored
TIMEOUT_CYCLES, 4096, inter-byte gap limit in CLK cycles; used only with CMD_TIMEOUT_EN

Ports:
CLK  input  1  system clock
RST  input  1  asynchronous active-low reset
RX_P_DATA  input  DATA_WIDTH  received byte
RX_D_VLD  input  1  one-cycle pulse; RX_P_DATA valid
RF_RdData  input  DATA_WIDTH  register read data
RF_RdData_Valid  input  1  read data valid pulse
ALU_OUT  input  2*DATA_WIDTH  ALU result
ALU_OUT_Valid  input  1  ALU result valid pulse
TX_FIFO_FULL  input  1  TX FIFO cannot accept a write
RF_WrEn  output  1  register write strobe, one cycle
RF_RdEn  output  1  register read strobe, one cycle
RF_Address  output  ADDR_WIDTH  register address
RF_WrData  output  DATA_WIDTH  register write data
ALU_EN  output  1  ALU start strobe, one cycle
ALU_FUN  output  4  ALU function code
CLK_GATE_EN  output  1  enable for the ALU gated clock
TX_P_DATA  output  DATA_WIDTH  response byte
TX_D_VLD  output  1  TX FIFO write pulse, one cycle

Behaviour:
- All outputs are registered. Reset value is 0 for every output, and the FSM resets to IDLE. A reset mid-frame aborts the frame immediately with no further strobes.
- Frames: 0xAA addr data = write. 0xBB addr = read. 0xCC opA opB fun = ALU with operands. 0xDD fun = ALU without operands.
- Any other byte in IDLE is discarded and the FSM stays in IDLE.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, ALU_OPA, ALU_OPB, ALU_FUN, ALU_WAIT, TX_B0, TX_B1. The FSM advances only on RX_D_VLD in the byte-collecting states.
- IDLE transitions on the command byte: 0xAA->WR_ADDR, 0xBB->RD_ADDR, 0xCC->ALU_OPA, 0xDD->ALU_FUN.
- Write frame:
  - WR_ADDR latches the address, then goes to WR_DATA.
  - On the data byte, RF_WrEn=1 for exactly one cycle, in the cycle after that RX_D_VLD. RF_Address and RF_WrData are valid in the same cycle. Next state is IDLE.
- Read frame:
  - On the addr byte, RF_RdEn=1 for one cycle (next cycle), then RD_WAIT.
  - RD_WAIT captures RF_RdData when RF_RdData_Valid=1, then goes to TX_B0.
- ALU frame with operands:
  - opA byte -> RF_WrEn pulse, RF_Address=0, RF_WrData=opA; then ALU_OPB.
  - opB byte -> RF_WrEn pulse, RF_Address=1; then ALU_FUN.
- ALU_FUN: on the fun byte, ALU_FUN=fun[3:0] and ALU_EN=1 for one cycle (next cycle), then ALU_WAIT. ALU_FUN holds its value until the next fun byte.
- CLK_GATE_EN is 1 whenever the state is ALU_FUN or ALU_WAIT, and also in the ALU_EN cycle. It is 0 otherwise.
- ALU_WAIT captures ALU_OUT on ALU_OUT_Valid, then goes to TX_B0.
- TX_B0 sends the read byte or ALU_OUT[DATA_WIDTH-1:0]. TX_B1 sends ALU_OUT[2*DATA_WIDTH-1:DATA_WIDTH] (ALU path only), then IDLE. The read path goes from TX_B0 to IDLE.
- TX write: a TX_D_VLD pulse is issued only in a cycle where TX_FIFO_FULL=0. While full, the FSM holds the state and TX_P_DATA, and issues no pulse. No byte is ever dropped or duplicated.
- RX_D_VLD in RD_WAIT, ALU_WAIT, TX_B0 or TX_B1 is discarded; no queueing.
- Simultaneous events: RX_D_VLD in the same cycle as a state exit is evaluated against the current state only.
- Strobes RF_WrEn, RF_RdEn, ALU_EN and TX_D_VLD are never high for two consecutive cycles.

Optional Feature:
CMD_TIMEOUT_EN:
- Defined: a counter resets on every RX_D_VLD. If it reaches TIMEOUT_CYCLES while in WR_ADDR, WR_DATA, RD_ADDR, ALU_OPA, ALU_OPB or ALU_FUN, the FSM returns to IDLE with no strobes and CLK_GATE_EN drops next cycle. Wait and TX states are not timed.
- Undefined: no counter; partial frames wait indefinitely.

Test Plan:
- Reset, then bytes 0xAA,0x05,0x3C -> one RF_WrEn pulse with RF_Address=5 and RF_WrData=0x3C, one cycle after the third RX_D_VLD; no TX_D_VLD.
- 0xBB,0x02, RF_RdData=0x7E valid 3 cycles later -> RF_RdEn pulse with addr 2, then one TX_D_VLD with TX_P_DATA=0x7E.
- 0xCC,0x10,0x20,0x01 -> RF_WrEn at addr0=0x10 and addr1=0x20, ALU_EN with ALU_FUN=1, CLK_GATE_EN high. Then ALU_OUT=0x0030 -> TX bytes 0x30 then 0x00.
- 0xDD,0x02 with TX_FIFO_FULL=1 for 10 cycles after ALU_OUT_Valid (ALU_OUT=0x1234) -> no TX_D_VLD while full, then 0x34 then 0x12 exactly once each.
- Byte 0x55 in IDLE, then 0xBB,0x03 while 0xAA arrives during RD_WAIT -> 0x55 and 0xAA ignored; only the read completes.
- Assert RST after 0xCC,0x10 -> all outputs 0 and FSM in IDLE. With CMD_TIMEOUT_EN and TIMEOUT_CYCLES=16: 0xAA then an idle line -> return to IDLE after 16 cycles; following 0xAA,0x01,0x02 writes normally.

Source files
------------

// File: rtl/uart_rx_cmd_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_cmd_decoder_if
// Description : Bundle of the command decoder's data-path signals: RX byte
//               input, register-file strobes, ALU control/result and TX FIFO
//               write port. master = decoder side, slave = surrounding logic.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_cmd_decoder_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    // RX side
    logic [DATA_WIDTH-1:0]   RX_P_DATA;
    logic                    RX_D_VLD;
    // Register file
    logic [DATA_WIDTH-1:0]   RF_RdData;
    logic                    RF_RdData_Valid;
    logic                    RF_WrEn;
    logic                    RF_RdEn;
    logic [ADDR_WIDTH-1:0]   RF_Address;
    logic [DATA_WIDTH-1:0]   RF_WrData;
    // ALU
    logic [2*DATA_WIDTH-1:0] ALU_OUT;
    logic                    ALU_OUT_Valid;
    logic                    ALU_EN;
    logic [3:0]              ALU_FUN;
    logic                    CLK_GATE_EN;
    // TX FIFO write port
    logic                    TX_FIFO_FULL;
    logic [DATA_WIDTH-1:0]   TX_P_DATA;
    logic                    TX_D_VLD;

    modport master (
        input  RX_P_DATA, RX_D_VLD,
        input  RF_RdData, RF_RdData_Valid,
        input  ALU_OUT, ALU_OUT_Valid,
        input  TX_FIFO_FULL,
        output RF_WrEn, RF_RdEn, RF_Address, RF_WrData,
        output ALU_EN, ALU_FUN, CLK_GATE_EN,
        output TX_P_DATA, TX_D_VLD
    );

    modport slave (
        output RX_P_DATA, RX_D_VLD,
        output RF_RdData, RF_RdData_Valid,
        output ALU_OUT, ALU_OUT_Valid,
        output TX_FIFO_FULL,
        input  RF_WrEn, RF_RdEn, RF_Address, RF_WrData,
        input  ALU_EN, ALU_FUN, CLK_GATE_EN,
        input  TX_P_DATA, TX_D_VLD
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_cmd_decoder
// Description : Decodes UART command frames into register-file write/read
//               strobes and ALU operations, and returns read data / ALU
//               results byte-wise to the TX FIFO.
//               Frames: AA addr data | BB addr | CC opA opB fun | DD fun
//               Optional macro CMD_TIMEOUT_EN: abandon a partial frame after
//               TIMEOUT_CYCLES cycles without a received byte.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_cmd_decoder #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  wire                   CLK,
    input  wire                   RST,
    uart_rx_cmd_decoder_if.master dec_if
);

    localparam logic [DATA_WIDTH-1:0] CMD_WR      = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] CMD_RD      = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_OP  = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU_NOP = DATA_WIDTH'(8'hDD);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_WR_ADDR  = 4'd1,
        S_WR_DATA  = 4'd2,
        S_RD_ADDR  = 4'd3,
        S_RD_WAIT  = 4'd4,
        S_ALU_OPA  = 4'd5,
        S_ALU_OPB  = 4'd6,
        S_ALU_FUN  = 4'd7,
        S_ALU_WAIT = 4'd8,
        S_TX_B0    = 4'd9,
        S_TX_B1    = 4'd10
    } state_t;

    state_t                  state_q, state_d;
    logic                    rf_wren_q, rf_wren_d;
    logic                    rf_rden_q, rf_rden_d;
    logic [ADDR_WIDTH-1:0]   rf_addr_q, rf_addr_d;
    logic [DATA_WIDTH-1:0]   rf_wrdata_q, rf_wrdata_d;
    logic                    alu_en_q, alu_en_d;
    logic [3:0]              alu_fun_q, alu_fun_d;
    logic                    clk_gate_q, clk_gate_d;
    logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
    logic                    tx_vld_q, tx_vld_d;
    // Response buffer: read byte in the low half, or the full ALU result
    logic [2*DATA_WIDTH-1:0] res_q, res_d;
    // Set for ALU frames so TX_B0 knows a second byte follows
    logic                    alu_path_q, alu_path_d;
    logic                    w_timeout;
    logic                    w_tx_ok;

    // A TX write is allowed only when the FIFO has room and the previous
    // cycle was not itself a write, so the TX strobe is never back-to-back.
    assign w_tx_ok = !dec_if.TX_FIFO_FULL && !tx_vld_q;

`ifdef CMD_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMR_W-1:0] timer_q, timer_d;
    logic             w_collecting;

    assign w_collecting = (state_q == S_WR_ADDR) || (state_q == S_WR_DATA) ||
                          (state_q == S_RD_ADDR) || (state_q == S_ALU_OPA) ||
                          (state_q == S_ALU_OPB) || (state_q == S_ALU_FUN);

    // Cycles since the last received byte, saturating at the limit
    always_comb begin
        timer_d = timer_q;
        if (dec_if.RX_D_VLD) begin
            timer_d = '0;
        end else if (timer_q != TMR_W'(TIMEOUT_CYCLES)) begin
            timer_d = timer_q + 1'b1;
        end
    end

    // A byte arriving in the expiry cycle still wins over the timeout
    assign w_timeout = w_collecting && !dec_if.RX_D_VLD &&
                       (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));

    // Inter-byte gap counter register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end
`else
    // Partial frames wait indefinitely; the limit parameter has no effect.
    wire w_unused_timeout = ^TIMEOUT_CYCLES;
    assign w_timeout = 1'b0;
`endif

    // Next-state and output decode; strobes default low, data registers hold
    always_comb begin
        state_d     = state_q;
        rf_wren_d   = 1'b0;
        rf_rden_d   = 1'b0;
        alu_en_d    = 1'b0;
        tx_vld_d    = 1'b0;
        rf_addr_d   = rf_addr_q;
        rf_wrdata_d = rf_wrdata_q;
        alu_fun_d   = alu_fun_q;
        tx_data_d   = tx_data_q;
        res_d       = res_q;
        alu_path_d  = alu_path_q;

        case (state_q)
            S_IDLE: begin
                if (dec_if.RX_D_VLD) begin
                    case (dec_if.RX_P_DATA)
                        CMD_WR:      state_d = S_WR_ADDR;
                        CMD_RD:      state_d = S_RD_ADDR;
                        CMD_ALU_OP:  state_d = S_ALU_OPA;
                        CMD_ALU_NOP: state_d = S_ALU_FUN;
                        default:     state_d = S_IDLE;
                    endcase
                end
            end
            S_WR_ADDR: begin
                if (dec_if.RX_D_VLD) begin
                    rf_addr_d = dec_if.RX_P_DATA[ADDR_WIDTH-1:0];
                    state_d   = S_WR_DATA;
                end
            end
            S_WR_DATA: begin
                if (dec_if.RX_D_VLD) begin
                    rf_wren_d   = 1'b1;
                    rf_wrdata_d = dec_if.RX_P_DATA;
                    state_d     = S_IDLE;
                end
            end
            S_RD_ADDR: begin
                if (dec_if.RX_D_VLD) begin
                    rf_rden_d  = 1'b1;
                    rf_addr_d  = dec_if.RX_P_DATA[ADDR_WIDTH-1:0];
                    alu_path_d = 1'b0;
                    state_d    = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (dec_if.RF_RdData_Valid) begin
                    res_d   = {{DATA_WIDTH{1'b0}}, dec_if.RF_RdData};
                    state_d = S_TX_B0;
                end
            end
            S_ALU_OPA: begin
                if (dec_if.RX_D_VLD) begin
                    rf_wren_d   = 1'b1;
                    rf_addr_d   = ADDR_WIDTH'(0);
                    rf_wrdata_d = dec_if.RX_P_DATA;
                    state_d     = S_ALU_OPB;
                end
            end
            S_ALU_OPB: begin
                if (dec_if.RX_D_VLD) begin
                    rf_wren_d   = 1'b1;
                    rf_addr_d   = ADDR_WIDTH'(1);
                    rf_wrdata_d = dec_if.RX_P_DATA;
                    state_d     = S_ALU_FUN;
                end
            end
            S_ALU_FUN: begin
                if (dec_if.RX_D_VLD) begin
                    alu_en_d   = 1'b1;
                    alu_fun_d  = dec_if.RX_P_DATA[3:0];
                    alu_path_d = 1'b1;
                    state_d    = S_ALU_WAIT;
                end
            end
            S_ALU_WAIT: begin
                if (dec_if.ALU_OUT_Valid) begin
                    res_d   = dec_if.ALU_OUT;
                    state_d = S_TX_B0;
                end
            end
            S_TX_B0: begin
                if (w_tx_ok) begin
                    tx_vld_d  = 1'b1;
                    tx_data_d = res_q[DATA_WIDTH-1:0];
                    state_d   = alu_path_q ? S_TX_B1 : S_IDLE;
                end
            end
            S_TX_B1: begin
                if (w_tx_ok) begin
                    tx_vld_d  = 1'b1;
                    tx_data_d = res_q[2*DATA_WIDTH-1:DATA_WIDTH];
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Timeout only fires without a byte, so no strobe is pending here
        if (w_timeout) begin
            state_d = S_IDLE;
        end

        // Gated ALU clock runs through ALU_FUN/ALU_WAIT; the ALU_EN cycle is
        // the first ALU_WAIT cycle, so it is covered as well.
        clk_gate_d = (state_d == S_ALU_FUN) || (state_d == S_ALU_WAIT);
    end

    // FSM state and registered outputs
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= S_IDLE;
            rf_wren_q   <= 1'b0;
            rf_rden_q   <= 1'b0;
            rf_addr_q   <= '0;
            rf_wrdata_q <= '0;
            alu_en_q    <= 1'b0;
            alu_fun_q   <= '0;
            clk_gate_q  <= 1'b0;
            tx_data_q   <= '0;
            tx_vld_q    <= 1'b0;
            res_q       <= '0;
            alu_path_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rf_wren_q   <= rf_wren_d;
            rf_rden_q   <= rf_rden_d;
            rf_addr_q   <= rf_addr_d;
            rf_wrdata_q <= rf_wrdata_d;
            alu_en_q    <= alu_en_d;
            alu_fun_q   <= alu_fun_d;
            clk_gate_q  <= clk_gate_d;
            tx_data_q   <= tx_data_d;
            tx_vld_q    <= tx_vld_d;
            res_q       <= res_d;
            alu_path_q  <= alu_path_d;
        end
    end

    assign dec_if.RF_WrEn     = rf_wren_q;
    assign dec_if.RF_RdEn     = rf_rden_q;
    assign dec_if.RF_Address  = rf_addr_q;
    assign dec_if.RF_WrData   = rf_wrdata_q;
    assign dec_if.ALU_EN      = alu_en_q;
    assign dec_if.ALU_FUN     = alu_fun_q;
    assign dec_if.CLK_GATE_EN = clk_gate_q;
    assign dec_if.TX_P_DATA   = tx_data_q;
    assign dec_if.TX_D_VLD    = tx_vld_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_cmd_decoder
// Description : Scoreboard bench for uart_rx_cmd_decoder. Stimulus pushes the
//               expected strobe/TX events; a negedge monitor pops and compares
//               whenever the DUT raises a strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_cmd_decoder;

    localparam int DW = 8;
    localparam int AW = 4;
`ifdef CMD_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 4096;
`endif

    localparam int K_WR  = 1;
    localparam int K_RD  = 2;
    localparam int K_ALU = 3;
    localparam int K_TX  = 4;

    typedef struct {
        int kind;
        int a;
        int b;
        int cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   last_cyc;
    int   checks;
    int   errors;
    logic full_s;
    logic prev_wr, prev_rd, prev_alu, prev_tx;
    exp_t sb_q[$];

    uart_rx_cmd_decoder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    uart_rx_cmd_decoder #(
        .DATA_WIDTH    (DW),
        .ADDR_WIDTH    (AW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .CLK   (clk),
        .RST   (rst_n),
        .dec_if(bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) begin
        cyc    = cyc + 1;
        full_s = bus.TX_FIFO_FULL;
    end

    task automatic push(input int k, input int a, input int b, input int c);
        exp_t e;
        e.kind = k; e.a = a; e.b = b; e.cyc = c;
        sb_q.push_back(e);
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_evt(input int k, input int a, input int b);
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: kind %0d a=%0h b=%0h at cyc %0d, expected none", k, a, b, cyc);
        end else begin
            e = sb_q.pop_front();
            if (e.kind != k || e.a != a || e.b != b || (e.cyc >= 0 && e.cyc != cyc)) begin
                errors++;
                $display("FAIL event: got kind %0d a=%0h b=%0h cyc %0d, expected kind %0d a=%0h b=%0h cyc %0d",
                         k, a, b, cyc, e.kind, e.a, e.b, e.cyc);
            end
        end
    endtask

    task automatic check_strobe_gap(input string name, input logic prev);
        checks++;
        if (prev) begin
            errors++;
            $display("FAIL %s_back_to_back: got high two cycles, expected single pulse", name);
        end
    endtask

    // Monitor: every strobe seen mid-cycle is matched against the scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.RF_WrEn) begin
                check_evt(K_WR, int'(bus.RF_Address), int'(bus.RF_WrData));
                check_strobe_gap("wren", prev_wr);
            end
            if (bus.RF_RdEn) begin
                check_evt(K_RD, int'(bus.RF_Address), 0);
                check_strobe_gap("rden", prev_rd);
            end
            if (bus.ALU_EN) begin
                check_evt(K_ALU, int'(bus.ALU_FUN), int'(bus.CLK_GATE_EN));
                check_strobe_gap("alu_en", prev_alu);
            end
            if (bus.TX_D_VLD) begin
                check_evt(K_TX, int'(bus.TX_P_DATA), 0);
                check_strobe_gap("tx_vld", prev_tx);
                check_val("tx_while_full", int'(full_s), 0);
            end
        end
        prev_wr  = bus.RF_WrEn;
        prev_rd  = bus.RF_RdEn;
        prev_alu = bus.ALU_EN;
        prev_tx  = bus.TX_D_VLD;
    end

    task automatic send_byte(input logic [DW-1:0] b);
        repeat (2) @(negedge clk);
        bus.RX_P_DATA = b;
        bus.RX_D_VLD  = 1'b1;
        @(posedge clk);
        #1;
        bus.RX_D_VLD = 1'b0;
        last_cyc     = cyc;
    endtask

    task automatic pulse_rd(input logic [DW-1:0] d);
        @(negedge clk);
        bus.RF_RdData       = d;
        bus.RF_RdData_Valid = 1'b1;
        @(negedge clk);
        bus.RF_RdData_Valid = 1'b0;
    endtask

    task automatic pulse_alu(input logic [2*DW-1:0] d);
        @(negedge clk);
        bus.ALU_OUT       = d;
        bus.ALU_OUT_Valid = 1'b1;
        @(negedge clk);
        bus.ALU_OUT_Valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_val({name, "_pending"}, sb_q.size(), 0);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_wren"},  int'(bus.RF_WrEn), 0);
        check_val({tag, "_rden"},  int'(bus.RF_RdEn), 0);
        check_val({tag, "_addr"},  int'(bus.RF_Address), 0);
        check_val({tag, "_wdata"}, int'(bus.RF_WrData), 0);
        check_val({tag, "_alu_en"}, int'(bus.ALU_EN), 0);
        check_val({tag, "_alu_fun"}, int'(bus.ALU_FUN), 0);
        check_val({tag, "_cg"},    int'(bus.CLK_GATE_EN), 0);
        check_val({tag, "_txd"},   int'(bus.TX_P_DATA), 0);
        check_val({tag, "_txv"},   int'(bus.TX_D_VLD), 0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        full_s = 1'b0;
        prev_wr = 1'b0; prev_rd = 1'b0; prev_alu = 1'b0; prev_tx = 1'b0;
        last_cyc = 0;
        rst_n = 1'b0;
        bus.RX_P_DATA = '0;
        bus.RX_D_VLD = 1'b0;
        bus.RF_RdData = '0;
        bus.RF_RdData_Valid = 1'b0;
        bus.ALU_OUT = '0;
        bus.ALU_OUT_Valid = 1'b0;
        bus.TX_FIFO_FULL = 1'b0;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Write frame
        send_byte(8'hAA); send_byte(8'h05); send_byte(8'h3C);
        push(K_WR, 5, 8'h3C, last_cyc);
        drain("write");

        // Read frame, data returns three cycles later
        send_byte(8'hBB); send_byte(8'h02);
        push(K_RD, 2, 0, last_cyc);
        repeat (2) @(negedge clk);
        push(K_TX, 8'h7E, 0, -1);
        pulse_rd(8'h7E);
        drain("read");

        // ALU frame with operands
        send_byte(8'hCC); send_byte(8'h10);
        push(K_WR, 0, 8'h10, last_cyc);
        send_byte(8'h20);
        push(K_WR, 1, 8'h20, last_cyc);
        send_byte(8'h01);
        push(K_ALU, 1, 1, last_cyc);
        repeat (2) @(negedge clk);
        check_val("cg_in_alu_wait", int'(bus.CLK_GATE_EN), 1);
        push(K_TX, 8'h30, 0, -1);
        push(K_TX, 8'h00, 0, -1);
        pulse_alu(16'h0030);
        drain("alu_ops");
        check_val("cg_after_alu", int'(bus.CLK_GATE_EN), 0);
        check_val("alu_fun_hold", int'(bus.ALU_FUN), 1);

        // ALU frame without operands, TX FIFO full for 10 cycles
        send_byte(8'hDD);
        @(negedge clk);
        check_val("cg_in_alu_fun", int'(bus.CLK_GATE_EN), 1);
        send_byte(8'h02);
        push(K_ALU, 2, 1, last_cyc);
        push(K_TX, 8'h34, 0, -1);
        push(K_TX, 8'h12, 0, -1);
        @(negedge clk);
        bus.TX_FIFO_FULL = 1'b1;
        pulse_alu(16'h1234);
        repeat (10) @(negedge clk);
        check_val("held_while_full", sb_q.size(), 2);
        bus.TX_FIFO_FULL = 1'b0;
        drain("alu_full");

        // Junk byte in IDLE, command byte during RD_WAIT: both ignored
        send_byte(8'h55);
        send_byte(8'hBB); send_byte(8'h03);
        push(K_RD, 3, 0, last_cyc);
        send_byte(8'hAA);
        push(K_TX, 8'h5A, 0, -1);
        pulse_rd(8'h5A);
        drain("ignore");
        send_byte(8'hAA); send_byte(8'h07); send_byte(8'h99);
        push(K_WR, 7, 8'h99, last_cyc);
        drain("after_ignore");

        // Reset mid-frame
        send_byte(8'hCC); send_byte(8'h10);
        push(K_WR, 0, 8'h10, last_cyc);
        drain("pre_reset");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        send_byte(8'hAA); send_byte(8'h0A); send_byte(8'h0B);
        push(K_WR, 8'h0A, 8'h0B, last_cyc);
        drain("post_reset");

`ifdef CMD_TIMEOUT_EN
        // Abandoned write frame times out, next frame decodes normally
        send_byte(8'hAA);
        repeat (TO + 4) @(negedge clk);
        send_byte(8'hAA); send_byte(8'h01); send_byte(8'h02);
        push(K_WR, 1, 2, last_cyc);
        drain("timeout_wr");
        // Abandoned ALU_FUN drops the clock gate
        send_byte(8'hDD);
        @(negedge clk);
        check_val("to_cg_on", int'(bus.CLK_GATE_EN), 1);
        repeat (TO + 4) @(negedge clk);
        check_val("to_cg_off", int'(bus.CLK_GATE_EN), 0);
`endif

        repeat (5) @(negedge clk);
        check_val("scoreboard_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
